// File: rtl/param_pingpong_buf.sv
// Double-buffered EPU parameter store. The host bursts into the fill bank while the EPU
// works on the active bank, and a swap exchanges the two banks between layers.
module param_pingpong_buf #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int AW     = $clog2(DEPTH),
   parameter int LEN_W  = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                host_req,
   input  logic                host_we,
   input  logic [AW-1:0]       host_addr,
   input  logic [LEN_W-1:0]    host_len,
   output logic                host_ack,
   input  logic                host_wvalid,
   input  logic [DATA_W-1:0]   host_wdata,
   input  logic [DATA_W/8-1:0] host_wstrb,
   output logic                host_wready,
   output logic                host_rvalid,
   output logic [DATA_W-1:0]   host_rdata,
   output logic                host_rlast,
   input  logic                host_rready,
   input  logic                epu_start_i,
   input  logic                epu_finish_i,
   input  logic                epu_cs,
   input  logic                epu_we,
   input  logic [AW-1:0]       epu_addr,
   input  logic [DATA_W-1:0]   epu_wdata,
   output logic [DATA_W-1:0]   epu_rdata,
   input  logic                swap_i,
   output logic                swap_pending_o,
   output logic                active_bank_o,
   output logic                epu_busy_o
);
   localparam int NB = DATA_W / 8;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WR       = 2'd1,
      S_RD       = 2'd2,
      S_RD_DRAIN = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Both banks in one array: the top index bit selects the bank.
   logic [DATA_W-1:0] r_mem [0:2*DEPTH-1];

   logic [AW-1:0]     r_addr;
   logic [LEN_W-1:0]  r_left;
   logic              r_ack;
   logic              r_wready;
   logic              r_rvalid;
   logic              r_rlast;
   logic [DATA_W-1:0] r_rdata;
   logic [DATA_W-1:0] r_epu_rdata;
   logic              r_active;
   logic              r_swap_pending;
   logic              r_busy;

   logic              w_swap_go;
   logic              w_accept;
   logic              w_wr_beat;
   logic              w_rd_issue;
   logic              w_last;
   logic              w_drain_done;
   logic              w_epu_wr;
   logic              w_epu_rd;
   logic [AW:0]       w_fill_idx;
   logic [AW:0]       w_epu_idx;

   // A pending swap wins over a new host command in the same idle cycle.
   assign w_swap_go    = r_swap_pending && (r_state == S_IDLE) && !r_busy;
   assign w_accept     = (r_state == S_IDLE) && host_req && !w_swap_go;
   assign w_wr_beat    = (r_state == S_WR) && host_wvalid;
   assign w_rd_issue   = (r_state == S_RD) && (!r_rvalid || host_rready);
   assign w_last       = (r_left == {LEN_W{1'b0}});
   assign w_drain_done = (r_state == S_RD_DRAIN) && r_rvalid && r_rlast && host_rready;
   assign w_epu_wr     = r_busy && epu_cs && epu_we;
   assign w_epu_rd     = r_busy && epu_cs && !epu_we;
   assign w_fill_idx   = {~r_active, r_addr};
   assign w_epu_idx    = {r_active, epu_addr};

   // Host FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Host FSM next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (host_we) begin
                  w_state_next = S_WR;
               end else begin
                  w_state_next = S_RD;
               end
            end else begin
               w_state_next = S_IDLE;
            end
         end
         S_WR: begin
            if (w_wr_beat && w_last) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_WR;
            end
         end
         S_RD: begin
            if (w_rd_issue && w_last) begin
               w_state_next = S_RD_DRAIN;
            end else begin
               w_state_next = S_RD;
            end
         end
         S_RD_DRAIN: begin
            if (w_drain_done) begin
               w_state_next = S_IDLE;
            end else begin
               w_state_next = S_RD_DRAIN;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Burst address/count tracking and host handshake outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr   <= {AW{1'b0}};
         r_left   <= {LEN_W{1'b0}};
         r_ack    <= 1'b0;
         r_wready <= 1'b0;
         r_rvalid <= 1'b0;
         r_rlast  <= 1'b0;
      end else begin
         r_ack <= w_accept;
         if (w_accept) begin
            r_addr   <= host_addr;
            r_left   <= host_len;
            r_wready <= host_we;
         end else if (w_wr_beat || w_rd_issue) begin
            r_addr <= r_addr + AW'(1);
            r_left <= r_left - LEN_W'(1);
            if (w_wr_beat && w_last) begin
               r_wready <= 1'b0;
            end
         end
         if (w_rd_issue) begin
            r_rvalid <= 1'b1;
            r_rlast  <= w_last;
         end else if (host_rready) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
         end
      end
   end

   // Bank ownership, swap request and EPU layer tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_active       <= 1'b0;
         r_swap_pending <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         if (w_swap_go) begin
            r_active       <= ~r_active;
            r_swap_pending <= 1'b0;
         end else if (swap_i) begin
            r_swap_pending <= 1'b1;
         end
         if (epu_start_i && !epu_finish_i) begin
            r_busy <= 1'b1;
         end else if (epu_finish_i && !epu_start_i) begin
            r_busy <= 1'b0;
         end
      end
   end

   // Storage writes; reset blocks any beat presented alongside it
   always_ff @(posedge clk) begin
      if (!rst && w_wr_beat) begin
         for (int b = 0; b < NB; b++) begin
            if (host_wstrb[b]) begin
               r_mem[w_fill_idx][b*8 +: 8] <= host_wdata[b*8 +: 8];
            end
         end
      end
      if (!rst && w_epu_wr) begin
         r_mem[w_epu_idx] <= epu_wdata;
      end
   end

   // Synchronous read ports; data registers hold until the next read
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata     <= {DATA_W{1'b0}};
         r_epu_rdata <= {DATA_W{1'b0}};
      end else begin
         if (w_rd_issue) begin
            r_rdata <= r_mem[w_fill_idx];
         end
         if (w_epu_rd) begin
            r_epu_rdata <= r_mem[w_epu_idx];
         end
      end
   end

   assign host_ack       = r_ack;
   assign host_wready    = r_wready;
   assign host_rvalid    = r_rvalid;
   assign host_rdata     = r_rdata;
   assign host_rlast     = r_rlast;
   assign epu_rdata      = r_busy ? r_epu_rdata : {DATA_W{1'b0}};
   assign swap_pending_o = r_swap_pending;
   assign active_bank_o  = r_active;
   assign epu_busy_o     = r_busy;

endmodule

// File: tb/tb_param_pingpong_buf.sv
// Directed/randomised bench for param_pingpong_buf against a two-bank array model.
module tb_param_pingpong_buf;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 64;
   localparam int AW     = 6;
   localparam int LEN_W  = 8;

   logic              clk;
   logic              rst;
   logic              host_req, host_we, host_ack;
   logic [AW-1:0]     host_addr;
   logic [LEN_W-1:0]  host_len;
   logic              host_wvalid, host_wready;
   logic [DATA_W-1:0] host_wdata;
   logic [3:0]        host_wstrb;
   logic              host_rvalid, host_rlast, host_rready;
   logic [DATA_W-1:0] host_rdata;
   logic              epu_start_i, epu_finish_i, epu_cs, epu_we;
   logic [AW-1:0]     epu_addr;
   logic [DATA_W-1:0] epu_wdata, epu_rdata;
   logic              swap_i, swap_pending_o, active_bank_o, epu_busy_o;

   param_pingpong_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_len(host_len),
      .host_ack(host_ack), .host_wvalid(host_wvalid), .host_wdata(host_wdata),
      .host_wstrb(host_wstrb), .host_wready(host_wready), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata), .host_rlast(host_rlast), .host_rready(host_rready),
      .epu_start_i(epu_start_i), .epu_finish_i(epu_finish_i), .epu_cs(epu_cs),
      .epu_we(epu_we), .epu_addr(epu_addr), .epu_wdata(epu_wdata), .epu_rdata(epu_rdata),
      .swap_i(swap_i), .swap_pending_o(swap_pending_o), .active_bank_o(active_bank_o),
      .epu_busy_o(epu_busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   logic [DATA_W-1:0] mdl [2][DEPTH];
   int                m_active;
   logic [DATA_W-1:0] wd [0:255];
   logic [3:0]        ws [0:255];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_cmd(input logic we, input int addr, input int len);
      bit got;
      got = 1'b0;
      host_req  = 1'b1;
      host_we   = we;
      host_addr = addr[AW-1:0];
      host_len  = len[LEN_W-1:0];
      for (int k = 0; k < 20; k++) begin
         step();
         if (host_ack === 1'b1) begin
            got = 1'b1;
            break;
         end
      end
      host_req = 1'b0;
      check("host_ack", 32'(got), 32'd1);
   endtask

   task automatic host_write(input int addr, input int len, input bit gaps);
      int i;
      int cyc;
      int fill;
      int idx;
      i = 0;
      cyc = 0;
      fill = 1 - m_active;
      host_cmd(1'b1, addr, len);
      while (i <= len && cyc < 2000) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            host_wvalid = 1'b0;
         end else begin
            host_wvalid = 1'b1;
            host_wdata  = wd[i];
            host_wstrb  = ws[i];
            check("wready_in_burst", 32'(host_wready), 32'd1);
         end
         step();
         cyc++;
         if (host_wvalid) begin
            idx = (addr + i) % DEPTH;
            for (int b = 0; b < 4; b++) begin
               if (ws[i][b]) mdl[fill][idx][b*8 +: 8] = wd[i][b*8 +: 8];
            end
            i++;
         end
      end
      host_wvalid = 1'b0;
      check("wready_after_burst", 32'(host_wready), 32'd0);
   endtask

   // mode 0: rready always high, 1: random rready, 2: stall first beat 3 cycles
   task automatic host_read(input int addr, input int len, input int mode);
      int i, cyc, stall, first, lastc, fill;
      bit held, rr;
      logic [DATA_W-1:0] prev;
      i = 0; cyc = 0; stall = 0; first = -1; lastc = -1; held = 1'b0;
      prev = '0;
      fill = 1 - m_active;
      host_cmd(1'b0, addr, len);
      while (i <= len && cyc < 2000) begin
         if (held) begin
            check("rdata_stable", host_rdata, prev);
            check("rvalid_held", 32'(host_rvalid), 32'd1);
         end
         case (mode)
            0: rr = 1'b1;
            1: rr = ($urandom_range(0, 1) == 1);
            default: rr = !(i == 0 && host_rvalid && stall < 3);
         endcase
         if (mode == 2 && !rr) stall++;
         host_rready = rr;
         held = 1'b0;
         if (host_rvalid === 1'b1) begin
            if (first < 0) first = cyc;
            if (rr) begin
               check("rdata", host_rdata, mdl[fill][(addr + i) % DEPTH]);
               check("rlast", 32'(host_rlast), 32'(i == len));
               if (i == len) lastc = cyc;
               i++;
            end else begin
               held = 1'b1;
               prev = host_rdata;
            end
         end
         step();
         cyc++;
      end
      host_rready = 1'b0;
      check("read_beats", 32'(i), 32'(len + 1));
      if (mode == 0) begin
         check("first_beat_latency", 32'(first), 32'd1);
         check("beat_rate", 32'(lastc - first), 32'(len));
      end
      check("rvalid_after_burst", 32'(host_rvalid), 32'd0);
   endtask

   task automatic epu_write(input int a, input logic [DATA_W-1:0] d);
      epu_cs = 1'b1; epu_we = 1'b1; epu_addr = a[AW-1:0]; epu_wdata = d;
      step();
      epu_cs = 1'b0; epu_we = 1'b0;
      mdl[m_active][a] = d;
   endtask

   task automatic epu_read(input int a);
      epu_cs = 1'b1; epu_we = 1'b0; epu_addr = a[AW-1:0];
      step();
      epu_cs = 1'b0;
      check("epu_rdata", epu_rdata, mdl[m_active][a]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [DATA_W-1:0] nd0, nd1, nd2;
      rst = 1'b1; host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_len = '0;
      host_wvalid = 1'b0; host_wdata = '0; host_wstrb = '0; host_rready = 1'b0;
      epu_start_i = 1'b0; epu_finish_i = 1'b0; epu_cs = 1'b0; epu_we = 1'b0;
      epu_addr = '0; epu_wdata = '0; swap_i = 1'b0;
      m_active = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ack", 32'(host_ack), 32'd0);
      check("rst_wready", 32'(host_wready), 32'd0);
      check("rst_rvalid", 32'(host_rvalid), 32'd0);
      check("rst_rlast", 32'(host_rlast), 32'd0);
      check("rst_pending", 32'(swap_pending_o), 32'd0);
      check("rst_busy", 32'(epu_busy_o), 32'd0);
      check("rst_active", 32'(active_bank_o), 32'd0);
      check("rst_rdata", host_rdata, 32'd0);
      check("rst_epu_rdata", epu_rdata, 32'd0);
      rst = 1'b0;
      step();

      // basic burst into bank 1, swap with EPU idle, EPU reads it back
      wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
      for (int k = 0; k < 4; k++) ws[k] = 4'hF;
      host_write(0, 3, 1'b0);
      swap_i = 1'b1;
      step();
      swap_i = 1'b0;
      check("swap_req_pending", 32'(swap_pending_o), 32'd1);
      check("swap_req_active", 32'(active_bank_o), 32'd0);
      step();
      check("swap_done_pending", 32'(swap_pending_o), 32'd0);
      check("swap_done_active", 32'(active_bank_o), 32'd1);
      m_active = 1;
      epu_start_i = 1'b1;
      step();
      epu_start_i = 1'b0;
      check("busy_set", 32'(epu_busy_o), 32'd1);
      epu_read(2);
      for (int a = 10; a < 18; a++) epu_write(a, $urandom);
      for (int a = 10; a < 18; a++) epu_read(a);
      for (int a = 0; a < 4; a++) epu_read(a);

      // strobe merge into bank 0, plus concurrent host/EPU traffic
      wd[0] = 32'h0; ws[0] = 4'hF;
      host_write(5, 0, 1'b0);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'h5;
      host_write(5, 0, 1'b0);
      host_read(5, 0, 0);
      for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      fork
         host_write(40, 3, 1'b1);
         begin
            for (int a = 20; a < 24; a++) epu_write(a, $urandom);
         end
      join
      for (int a = 20; a < 24; a++) epu_read(a);
      epu_read(2);

      // swap requested while the EPU is busy waits for epu_finish_i
      swap_i = 1'b1;
      step();
      swap_i = 1'b0;
      check("busy_swap_pending", 32'(swap_pending_o), 32'd1);
      check("busy_swap_active", 32'(active_bank_o), 32'd1);
      repeat (3) step();
      check("busy_swap_still_pending", 32'(swap_pending_o), 32'd1);
      check("busy_swap_still_active", 32'(active_bank_o), 32'd1);
      epu_finish_i = 1'b1;
      step();
      epu_finish_i = 1'b0;
      check("finish_busy", 32'(epu_busy_o), 32'd0);
      check("finish_pending", 32'(swap_pending_o), 32'd1);
      check("finish_active", 32'(active_bank_o), 32'd1);
      check("idle_epu_rdata", epu_rdata, 32'd0);
      step();
      check("late_swap_active", 32'(active_bank_o), 32'd0);
      check("late_swap_pending", 32'(swap_pending_o), 32'd0);
      m_active = 0;
      epu_cs = 1'b1; epu_we = 1'b1; epu_addr = 6'd5; epu_wdata = 32'hFFFFFFFF;
      step();
      epu_cs = 1'b0; epu_we = 1'b0;

      // random bursts into bank 1, back-pressure, wrap and full-rate reads
      for (int k = 0; k < 20; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      host_write(20, 19, 1'b1);
      for (int k = 0; k < 6; k++) begin wd[k] = $urandom; ws[k] = 4'($urandom_range(0, 15)); end
      host_write(24, 5, 1'b1);
      host_read(20, 3, 2);
      host_read(10, 29, 1);
      for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      host_write(62, 3, 1'b0);
      host_read(62, 3, 1);
      host_read(0, 3, 0);
      host_read(10, 7, 0);

      // reset in the middle of a write burst into bank 0
      swap_i = 1'b1;
      step();
      swap_i = 1'b0;
      step();
      check("pre_reset_active", 32'(active_bank_o), 32'd1);
      m_active = 1;
      nd0 = $urandom; nd1 = $urandom; nd2 = $urandom;
      host_cmd(1'b1, 40, 3);
      host_wvalid = 1'b1; host_wstrb = 4'hF; host_wdata = nd0;
      step();
      mdl[0][40] = nd0;
      host_wdata = nd1;
      step();
      mdl[0][41] = nd1;
      host_wdata = nd2;
      rst = 1'b1;
      step();
      rst = 1'b0;
      host_wvalid = 1'b0;
      m_active = 0;
      check("mid_rst_wready", 32'(host_wready), 32'd0);
      check("mid_rst_ack", 32'(host_ack), 32'd0);
      check("mid_rst_active", 32'(active_bank_o), 32'd0);
      step();
      check("post_rst_wready", 32'(host_wready), 32'd0);
      host_read(0, 1, 0);
      epu_start_i = 1'b1;
      step();
      epu_start_i = 1'b0;
      for (int a = 40; a < 44; a++) epu_read(a);
      epu_read(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/param_pingpong_buf.md
Name: param_pingpong_buf

Overview:
Parametrised, double-buffered parameter store for the EPU, built on the single-bank 16 B parameter buffer wrapper.
- It holds two banks. The EPU reads and writes the "active" bank while the AXI-side EPU wrapper bursts the next layer's parameters into the "fill" bank.
- A swap command exchanges the banks between layers.
- It adds burst transfers, byte strobes, back-pressure and layer overlap, none of which the single-bank wrapper has.

Parameters:
DATA_W, 32, word width in bits; must be a multiple of 8.
DEPTH, 64, words per bank; must be a power of 2 and at least 2.
AW, $clog2(DEPTH), word-address width (derived; do not override).
LEN_W, 8, burst length field width; a burst is host_len+1 beats.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
host_req  in  1  burst command valid
host_we  in  1  1 = write burst, 0 = read burst
host_addr  in  AW  start word address within the fill bank
host_len  in  LEN_W  beats minus 1
host_ack  out  1  one-cycle pulse: command accepted
host_wvalid  in  1  write beat valid
host_wdata  in  DATA_W  write beat data
host_wstrb  in  DATA_W/8  byte enables
host_wready  out  1  write beat accepted
host_rvalid  out  1  read beat valid
host_rdata  out  DATA_W  read beat data
host_rlast  out  1  final beat of the read burst
host_rready  in  1  host takes the read beat
epu_start_i  in  1  pulse: EPU layer begins
epu_finish_i  in  1  pulse: EPU layer done
epu_cs  in  1  EPU access enable
epu_we  in  1  EPU write
epu_addr  in  AW  EPU word address within the active bank
epu_wdata  in  DATA_W  EPU write data
epu_rdata  out  DATA_W  EPU read data, one-cycle latency
swap_i  in  1  pulse: request bank exchange
swap_pending_o  out  1  swap requested but not yet performed
active_bank_o  out  1  bank currently owned by the EPU
epu_busy_o  out  1  EPU layer in progress

Behaviour:
Reset values:
- Host FSM goes to IDLE; active_bank_o=0 (fill bank is 1).
- Outputs host_ack, host_wready, host_rvalid, host_rlast, swap_pending_o and epu_busy_o are 0.
- host_rdata and epu_rdata are 0.
- Memory contents are not reset.

Memory:
- Two banks, each DEPTH x DATA_W, with synchronous read (data one cycle after the address) and per-byte write enable.

epu_busy_o:
- Set on epu_start_i; cleared on epu_finish_i. Both in the same cycle leaves it unchanged.
- While epu_busy_o=0, epu_cs is ignored (no write) and epu_rdata returns 0.
- While busy, epu_cs & epu_we writes epu_wdata (all bytes) to the active bank.
- epu_cs & !epu_we reads the active bank; epu_rdata is valid the next cycle and holds until the next EPU read.

Swap:
- swap_i sets swap_pending_o.
- The swap executes in the first cycle where swap_pending_o=1, host FSM=IDLE and epu_busy_o=0. In that cycle active_bank_o toggles and swap_pending_o clears.
- A swap_i arriving while a swap is already pending is absorbed (one swap only).

Host FSM states: IDLE, WR, RD, RD_DRAIN.
- IDLE: if host_req=1 and no swap executes this cycle, pulse host_ack, latch addr/len/we, then go to WR or RD.
- A swap executing in a cycle has priority; host_ack is delayed to a later cycle.
- WR:
  - host_wready=1.
  - Each beat with wvalid: write the fill bank at the current address using the strobe bytes.
  - Address increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - After host_len+1 beats, go to IDLE.
- RD:
  - Pipelined; one fill-bank read is issued when (!host_rvalid || host_rready) and beats remain to issue.
  - host_rvalid rises the cycle after issue. host_rdata is held stable while host_rvalid & !host_rready.
  - Address wraps modulo DEPTH.
  - Once the final beat is issued, go to RD_DRAIN.
- RD_DRAIN: return to IDLE when the final beat (host_rlast=1) is accepted.
- Sustained throughput is 1 beat/cycle with rready held high.
- host_len counts beats; bursts longer than DEPTH overwrite or re-read wrapped locations.

Isolation:
- The host never accesses the active bank and the EPU never accesses the fill bank. Both can operate in the same cycle.

Reset mid-operation:
- The burst is abandoned immediately. Writes already performed persist; no further writes occur.

Test Plan:
- Write burst: addr=0, len=3, data 0x11..0x44, wstrb=0xF; then swap_i with EPU idle; EPU reads addr 2 -> epu_rdata=0x33 one cycle later, active_bank_o=1.
- Strobe: write 0xAABBCCDD with wstrb=0x5 over 0x00000000, then read back -> 0x00BB00DD.
- Swap while busy: epu_start_i, then swap_i -> swap_pending_o=1 and bank unchanged; epu_finish_i -> bank toggles the next cycle and pending clears.
- Read back-pressure: 4-beat read with rready low for 3 cycles on beat 1 -> rdata stable during the stall, beats in order, rlast only on beat 4.
- Wrap: DEPTH=64, addr=62, len=3 write -> words 62, 63, 0, 1 written.
- Reset mid-write after 2 of 4 beats -> FSM in IDLE, wready=0, beats 3 and 4 not written, bank select back to 0.
